// File: rtl/song_player_pkg.sv
// Shared note, mode and song definitions used by the melody player, 7-seg display and tone stages.
// Also holds the player FSM state type and the note-code -> frequency lookup.
package song_player_pkg;

  localparam logic [31:0] DO_LOW  = 32'd131;
  localparam logic [31:0] RE_LOW  = 32'd147;
  localparam logic [31:0] MI_LOW  = 32'd165;
  localparam logic [31:0] FA_LOW  = 32'd175;
  localparam logic [31:0] SO_LOW  = 32'd196;
  localparam logic [31:0] LA_LOW  = 32'd220;
  localparam logic [31:0] SI_LOW  = 32'd247;
  localparam logic [31:0] DO      = 32'd262;
  localparam logic [31:0] RE      = 32'd294;
  localparam logic [31:0] MI      = 32'd330;
  localparam logic [31:0] FA      = 32'd349;
  localparam logic [31:0] SO      = 32'd392;
  localparam logic [31:0] LA      = 32'd440;
  localparam logic [31:0] SI      = 32'd494;
  localparam logic [31:0] DO_HIGH = 32'd523;
  localparam logic [31:0] RE_HIGH = 32'd587;
  localparam logic [31:0] MI_HIGH = 32'd659;
  localparam logic [31:0] FA_HIGH = 32'd698;
  localparam logic [31:0] SO_HIGH = 32'd784;
  localparam logic [31:0] LA_HIGH = 32'd880;
  localparam logic [31:0] SI_HIGH = 32'd988;

  typedef enum logic [1:0] {MODE_FREE = 2'd0, MODE_AUTO = 2'd1, MODE_LEARN = 2'd2} mode_e;
  typedef enum logic [1:0] {SONG1 = 2'd0, SONG2 = 2'd1, SONG3 = 2'd2} song_e;

  typedef enum logic [4:0] {
    N_REST = 5'd0,
    N_DO_L, N_RE_L, N_MI_L, N_FA_L, N_SO_L, N_LA_L, N_SI_L,
    N_DO_M, N_RE_M, N_MI_M, N_FA_M, N_SO_M, N_LA_M, N_SI_M,
    N_DO_H, N_RE_H, N_MI_H, N_FA_H, N_SO_H, N_LA_H, N_SI_H
  } note_e;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_NOTE, S_GAP, S_END} state_e;

  // Codes 22-31 fall through to silence, same as an explicit rest.
  function automatic logic [31:0] note_fre(input logic [4:0] code);
    logic [31:0] f;
    case (code)
      N_DO_L:  f = DO_LOW;
      N_RE_L:  f = RE_LOW;
      N_MI_L:  f = MI_LOW;
      N_FA_L:  f = FA_LOW;
      N_SO_L:  f = SO_LOW;
      N_LA_L:  f = LA_LOW;
      N_SI_L:  f = SI_LOW;
      N_DO_M:  f = DO;
      N_RE_M:  f = RE;
      N_MI_M:  f = MI;
      N_FA_M:  f = FA;
      N_SO_M:  f = SO;
      N_LA_M:  f = LA;
      N_SI_M:  f = SI;
      N_DO_H:  f = DO_HIGH;
      N_RE_H:  f = RE_HIGH;
      N_MI_H:  f = MI_HIGH;
      N_FA_H:  f = FA_HIGH;
      N_SO_H:  f = SO_HIGH;
      N_LA_H:  f = LA_HIGH;
      N_SI_H:  f = SI_HIGH;
      default: f = 32'd0;
    endcase
    return f;
  endfunction

  function automatic logic [7:0] rom_entry(input note_e note, input logic [2:0] beats);
    return {note, beats};
  endfunction

endpackage

// File: rtl/song_player_rom.sv
// Song table ROM: address {song[1:0], entry[5:0]}, entry = {note[4:0], beats[2:0]}, registered output.
// TEST_IMAGE selects a small fixed image used for simulation instead of the production songs.
module song_rom
  import song_player_pkg::*;
#(
  parameter bit TEST_IMAGE = 1'b0
) (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [7:0] word;

  always_comb begin
    word = 8'h00;
    if (TEST_IMAGE) begin
      case (addr)
        8'h00:   word = rom_entry(N_DO_M, 3'd1);
        8'h01:   word = rom_entry(N_REST, 3'd2);
        8'h02:   word = rom_entry(N_SI_H, 3'd3);
        8'h40:   word = rom_entry(N_DO_L, 3'd1);
        8'h41:   word = rom_entry(N_SO_L, 3'd1);
        8'h42:   word = {5'd25, 3'd1};
        8'h43:   word = rom_entry(N_SI_L, 3'd1);
        8'h44:   word = rom_entry(N_DO_M, 3'd1);
        8'h45:   word = rom_entry(N_SI_M, 3'd1);
        8'h46:   word = rom_entry(N_DO_H, 3'd1);
        8'h47:   word = rom_entry(N_SI_H, 3'd1);
        8'h80:   word = rom_entry(N_MI_M, 3'd2);
        default: word = 8'h00;
      endcase
    end else begin
      case (addr)
        // song1: twinkle twinkle
        8'h00:   word = rom_entry(N_DO_M, 3'd1);
        8'h01:   word = rom_entry(N_DO_M, 3'd1);
        8'h02:   word = rom_entry(N_SO_M, 3'd1);
        8'h03:   word = rom_entry(N_SO_M, 3'd1);
        8'h04:   word = rom_entry(N_LA_M, 3'd1);
        8'h05:   word = rom_entry(N_LA_M, 3'd1);
        8'h06:   word = rom_entry(N_SO_M, 3'd2);
        8'h07:   word = rom_entry(N_FA_M, 3'd1);
        8'h08:   word = rom_entry(N_FA_M, 3'd1);
        8'h09:   word = rom_entry(N_MI_M, 3'd1);
        8'h0A:   word = rom_entry(N_MI_M, 3'd1);
        8'h0B:   word = rom_entry(N_RE_M, 3'd1);
        8'h0C:   word = rom_entry(N_RE_M, 3'd1);
        8'h0D:   word = rom_entry(N_DO_M, 3'd2);
        // song2: ode to joy, first phrase
        8'h40:   word = rom_entry(N_MI_M, 3'd1);
        8'h41:   word = rom_entry(N_MI_M, 3'd1);
        8'h42:   word = rom_entry(N_FA_M, 3'd1);
        8'h43:   word = rom_entry(N_SO_M, 3'd1);
        8'h44:   word = rom_entry(N_SO_M, 3'd1);
        8'h45:   word = rom_entry(N_FA_M, 3'd1);
        8'h46:   word = rom_entry(N_MI_M, 3'd1);
        8'h47:   word = rom_entry(N_RE_M, 3'd1);
        8'h48:   word = rom_entry(N_DO_M, 3'd1);
        8'h49:   word = rom_entry(N_DO_M, 3'd1);
        8'h4A:   word = rom_entry(N_RE_M, 3'd1);
        8'h4B:   word = rom_entry(N_MI_M, 3'd1);
        8'h4C:   word = rom_entry(N_MI_M, 3'd2);
        8'h4D:   word = rom_entry(N_RE_M, 3'd1);
        8'h4E:   word = rom_entry(N_RE_M, 3'd2);
        // song3: rising scale with a rest before the top note
        8'h80:   word = rom_entry(N_DO_M, 3'd1);
        8'h81:   word = rom_entry(N_RE_M, 3'd1);
        8'h82:   word = rom_entry(N_MI_M, 3'd1);
        8'h83:   word = rom_entry(N_FA_M, 3'd1);
        8'h84:   word = rom_entry(N_SO_M, 3'd1);
        8'h85:   word = rom_entry(N_LA_M, 3'd1);
        8'h86:   word = rom_entry(N_SI_M, 3'd1);
        8'h87:   word = rom_entry(N_REST, 3'd1);
        8'h88:   word = rom_entry(N_DO_H, 3'd4);
        default: word = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) data <= word;

endmodule

// File: rtl/song_player.sv
// Melody sequencer: walks the song ROM and drives note frequency (fre) and song index (num).
// Define SONG_PLAYER_LOOP_EN to repeat the song until stop/!en instead of playing it once.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH   | ROM address {num,note_idx} presented
//   LOAD    | ROM word available: end marker -> END, else load note and beat timer
//   NOTE    | note sounding for beats*BEAT_CYC cycles
//   GAP     | silent articulation gap of GAP_CYC cycles
//   END     | one-cycle done pulse
module song_player
  import song_player_pkg::*;
#(
  parameter int unsigned BEAT_CYC   = 25_000_000,
  parameter int unsigned GAP_CYC    = 2_500_000,
  parameter int unsigned SONG_LEN   = 64,
  parameter int unsigned NUM_SONGS  = 3,
  parameter bit          TEST_IMAGE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  song_sel,
  output logic [31:0] fre,
  output logic [1:0]  num,
  output logic [5:0]  note_idx,
  output logic        playing,
  output logic        done
);

`ifdef SONG_PLAYER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [5:0]  LAST_IDX = 6'(SONG_LEN - 1);
  localparam logic [31:0] BEAT_LEN = 32'(BEAT_CYC);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYC - 1);

  state_e      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] fre_nxt;
  logic [1:0]  num_nxt;
  logic [5:0]  idx_nxt;
  logic        playing_nxt;
  logic [7:0]  rom_data;
  logic [4:0]  rom_note;
  logic [2:0]  rom_beats;
  logic        song_ok;

  assign rom_note  = rom_data[7:3];
  assign rom_beats = rom_data[2:0];
  assign song_ok   = 32'(song_sel) < NUM_SONGS;
  assign done      = (state == S_END);

  song_rom #(.TEST_IMAGE(TEST_IMAGE)) u_rom (
    .clk  (clk),
    .addr ({num, note_idx}),
    .data (rom_data)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fre_nxt     = fre;
    num_nxt     = num;
    idx_nxt     = note_idx;
    playing_nxt = playing;
    if (stop || !en) begin
      state_nxt   = S_IDLE;
      cnt_nxt     = '0;
      fre_nxt     = '0;
      playing_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && song_ok) begin
            num_nxt     = song_sel;
            idx_nxt     = '0;
            playing_nxt = 1'b1;
            state_nxt   = S_FETCH;
          end
        end
        S_FETCH: state_nxt = S_LOAD;
        S_LOAD: begin
          if (rom_beats == 3'd0) begin
            state_nxt = S_END;
          end else begin
            state_nxt = S_NOTE;
            fre_nxt   = note_fre(rom_note);
            cnt_nxt   = 32'(rom_beats) * BEAT_LEN - 32'd1;
          end
        end
        S_NOTE: begin
          if (cnt == '0) begin
            state_nxt = S_GAP;
            fre_nxt   = '0;
            cnt_nxt   = GAP_LOAD;
          end else begin
            cnt_nxt = cnt - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            if (note_idx == LAST_IDX) begin
              state_nxt = S_END;
            end else begin
              idx_nxt   = note_idx + 6'd1;
              state_nxt = S_FETCH;
            end
          end else begin
            cnt_nxt = cnt - 32'd1;
          end
        end
        S_END: begin
          fre_nxt = '0;
          if (LOOP_EN) begin
            idx_nxt   = '0;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      // Single-play drops playing together with the done pulse.
      if (!LOOP_EN && state_nxt == S_END) playing_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fre      <= '0;
      num      <= '0;
      note_idx <= '0;
      playing  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      fre      <= fre_nxt;
      num      <= num_nxt;
      note_idx <= idx_nxt;
      playing  <= playing_nxt;
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player with the test ROM image (BEAT_CYC=4, GAP_CYC=2, SONG_LEN=8).
// Stimulus pushes expected fre changes / done pulses with their cycle stamps; a monitor pops them.
module tb_song_player;
  import song_player_pkg::*;

  localparam int BEAT = 4;
  localparam int GAP  = 2;
`ifdef SONG_PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  // Hand-derived image: song0 mid do/rest/high si, song1 unterminated 8 entries, song2 mid mi.
  localparam int FRE_TAB [3][8] = '{'{262, 0, 988, 0, 0, 0, 0, 0},
                                    '{131, 196, 0, 247, 262, 494, 523, 988},
                                    '{330, 0, 0, 0, 0, 0, 0, 0}};
  localparam int BT_TAB  [3][8] = '{'{1, 2, 3, 0, 0, 0, 0, 0},
                                    '{1, 1, 1, 1, 1, 1, 1, 1},
                                    '{2, 0, 0, 0, 0, 0, 0, 0}};
  localparam int N_TAB   [3]    = '{3, 8, 1};
  localparam bit TERM_TAB[3]    = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    bit          is_done;
    logic [31:0] val;
    int          at;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  song_sel = 2'd0;
  logic [31:0] fre;
  logic [1:0]  num;
  logic [5:0]  note_idx;
  logic        playing;
  logic        done;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;
  logic [31:0] prev_fre = '0;
  ev_t         exp_q[$];

  song_player #(
    .BEAT_CYC  (BEAT),
    .GAP_CYC   (GAP),
    .SONG_LEN  (8),
    .NUM_SONGS (3),
    .TEST_IMAGE(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .song_sel (song_sel),
    .fre      (fre),
    .num      (num),
    .note_idx (note_idx),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit k, input logic [31:0] v, input int t);
    ev_t e;
    e.is_done = k;
    e.val     = v;
    e.at      = t;
    exp_q.push_back(e);
  endtask

  task automatic see(input bit k, input logic [31:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got done=%0d fre=%0d at cycle %0d, want none", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != k || e.val !== v || e.at != cyc) begin
        bad++;
        $display("FAIL event: got done=%0d fre=%0d cycle=%0d want done=%0d fre=%0d cycle=%0d",
                 k, v, cyc, e.is_done, e.val, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (fre !== prev_fre) see(1'b0, fre);
      if (done) see(1'b1, 32'd0);
    end
    prev_fre = fre;
  end

  // Entry fetched at edge t: fre at t+2 for beats*BEAT cycles, then GAP silent, next fetch.
  task automatic push_song(input int sel, input int s, input int reps, output int te);
    int t;
    t  = s;
    te = s;
    for (int p = 0; p < reps; p++) begin
      for (int i = 0; i < N_TAB[sel]; i++) begin
        if (FRE_TAB[sel][i] != 0) begin
          push(1'b0, 32'(FRE_TAB[sel][i]), t + 2);
          push(1'b0, 32'd0, t + 2 + BT_TAB[sel][i] * BEAT);
        end
        t = t + 2 + BT_TAB[sel][i] * BEAT + GAP;
      end
      te = TERM_TAB[sel] ? t + 2 : t;
      push(1'b1, 32'd0, te);
      t = te + 1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel, output int s);
    song_sel = sel;
    start    = 1'b1;
    s        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Full playback with a spurious start (song 2) injected mid-song that must be ignored.
  task automatic play_full(input int sel, input int reps);
    int s, te;
    pulse_start(2'(sel), s);
    push_song(sel, s, reps, te);
    while (cyc < te) begin
      @(negedge clk);
      if (cyc == s + 9) begin
        start    = 1'b1;
        song_sel = 2'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == te - 1) chk("playing_before_end", 32'(playing), 32'd1);
    end
    chk("playing_at_end", 32'(playing), LOOP ? 32'd1 : 32'd0);
    if (LOOP) en = 1'b0;
    @(negedge clk);
    chk("playing_after_end", 32'(playing), 32'd0);
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("num_latched", 32'(num), 32'(sel));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_fre", fre, 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_note_idx", 32'(note_idx), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    mon_on = 1'b1;

    // song 0 end to end (twice back-to-back when looping)
    play_full(0, LOOP ? 2 : 1);
    chk("song0_end_idx", 32'(note_idx), 32'd3);

    // song without terminator ends after entry 7's gap
    play_full(1, 1);
    chk("implicit_end_idx", 32'(note_idx), 32'd7);

    // invalid song, start+stop together, start with en low: all ignored
    pulse_start(2'd3, s);
    repeat (8) @(negedge clk);
    chk("bad_sel_playing", 32'(playing), 32'd0);
    chk("bad_sel_num", 32'(num), 32'd1);
    stop = 1'b1;
    pulse_start(2'd0, s);
    stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("stop_wins_playing", 32'(playing), 32'd0);
    chk("stop_wins_num", 32'(num), 32'd1);
    en = 1'b0;
    pulse_start(2'd0, s);
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("en_low_playing", 32'(playing), 32'd0);

    // stop during the second (rest) note
    pulse_start(2'd0, s);
    push(1'b0, 32'd262, s + 2);
    push(1'b0, 32'd0, s + 6);
    wait_cyc(s + 11);
    chk("mid_playing", 32'(playing), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_fre", fre, 32'd0);
    chk("stop_playing", 32'(playing), 32'd0);
    repeat (40) @(negedge clk);
    chk("stop_idx_hold", 32'(note_idx), 32'd1);
    chk("stop_queue", 32'(exp_q.size()), 32'd0);

    // stop while a note is sounding silences it on the next edge
    pulse_start(2'd0, s);
    push(1'b0, 32'd262, s + 2);
    push(1'b0, 32'd0, s + 4);
    wait_cyc(s + 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_note_fre", fre, 32'd0);
    repeat (10) @(negedge clk);

    // restart after stop replays from entry 0
    play_full(0, 1);

    // en dropped mid-note
    pulse_start(2'd2, s);
    push(1'b0, 32'd330, s + 2);
    push(1'b0, 32'd0, s + 4);
    wait_cyc(s + 3);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("en_drop_playing", 32'(playing), 32'd0);
    chk("en_drop_num", 32'(num), 32'd2);
    repeat (20) @(negedge clk);
    chk("en_drop_queue", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-note
    pulse_start(2'd2, s);
    push(1'b0, 32'd330, s + 2);
    push(1'b0, 32'd0, s + 5);
    wait_cyc(s + 4);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_playing", 32'(playing), 32'd0);
    chk("rst_mid_num", 32'(num), 32'd0);
    chk("rst_mid_idx", 32'(note_idx), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
